// File: rtl/rot_pkg.sv
// rot_pkg: shared types and helpers for the rotate sequencer.
//   state_t   : sequencer states (ST_IDLE, ST_RUN, ST_DONE)
//   DIR_LEFT / DIR_RIGHT : direction encoding of the dir input
//   rot1()    : one single-bit rotate of a ROT_WIDTH vector
package rot_pkg;

   localparam int unsigned ROT_WIDTH = 8;
   localparam int unsigned ROT_CNT_W = 3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Right: bit i takes bit i+1, MSB takes bit 0. Left: the mirror image.
   function automatic logic [ROT_WIDTH-1:0] rot1(input logic [ROT_WIDTH-1:0] v,
                                                  input logic                 right);
      if (right == DIR_RIGHT) begin
         rot1 = {v[0], v[ROT_WIDTH-1:1]};
      end else begin
         rot1 = {v[ROT_WIDTH-2:0], v[ROT_WIDTH-1]};
      end
   endfunction

endpackage

// File: rtl/rot_flag_gen.sv
// rot_flag_gen: combinational status flags for a data word.
//   value  : word to inspect
//   zero_c : value == 0
//   msb_c  : value[WIDTH-1]
module rot_flag_gen #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   output logic             zero_c,
   output logic             msb_c
);

   assign zero_c = (value == '0);
   assign msb_c  = value[WIDTH-1];

endmodule

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: multi-cycle rotate sequencer, one single-bit rotate per clock.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : request handshake (a, dir, amount)
//   out_valid/out_ready: result handshake (result, zero, msb)
//   busy               : sequencer not idle
// Optional macro ROT_SHORTPATH_EN: amounts above WIDTH/2 are executed as
// WIDTH-amount steps in the opposite direction (same result, lower latency).
module rotate_seq_ctrl
   import rot_pkg::*;
#(
   parameter int unsigned WIDTH = ROT_WIDTH,
   parameter int unsigned CNT_W = ROT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic             dir,
   input  logic [CNT_W-1:0] amount,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             msb,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic             dir_q;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] flag_src;
   logic             flag_zero;
   logic             flag_msb;
   logic             accept;
   logic             acc_dir;
   logic [CNT_W-1:0] acc_cnt;

   assign step_val = rot1(work, dir_q);
   assign accept   = in_valid && in_ready;

   // Flags come from the raw operand on a zero-amount accept, else from the final step.
   assign flag_src = (state == ST_IDLE) ? a : step_val;

   rot_flag_gen #(.WIDTH(WIDTH)) u_flags (
      .value  (flag_src),
      .zero_c (flag_zero),
      .msb_c  (flag_msb)
   );

   // Direction and step count latched at accept.
   always_comb begin
      acc_dir = dir;
      acc_cnt = amount;
`ifdef ROT_SHORTPATH_EN
      if (amount > CNT_W'(WIDTH / 2)) begin
         acc_dir = ~dir;
         acc_cnt = CNT_W'(WIDTH - 32'(amount));
      end
`endif
   end

   // Sequencer state, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         work      <= '0;
         dir_q     <= DIR_LEFT;
         cnt       <= '0;
         result    <= '0;
         zero      <= 1'b0;
         msb       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  work     <= a;
                  dir_q    <= acc_dir;
                  cnt      <= acc_cnt;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (acc_cnt == '0) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     result    <= a;
                     zero      <= flag_zero;
                     msb       <= flag_msb;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               work <= step_val;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= step_val;
                  zero      <= flag_zero;
                  msb       <= flag_msb;
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// tb_rotate_seq_ctrl: directed self-checking bench for rotate_seq_ctrl.
module tb_rotate_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic       dir;
   logic [2:0] amount;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;
   logic       msb;
   logic       busy;

   int n_tests;
   int n_fail;

   rotate_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .dir       (dir),
      .amount    (amount),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .msb       (msb),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, measure latency from the accepting edge, check result,
   // optionally hold out_ready low for 'hold' cycles, then complete the handshake.
   task automatic run_op(input string tag, input logic [7:0] av, input logic dv,
                         input logic [2:0] amt, input int exp_lat,
                         input logic [7:0] exp_res, input int hold, input bit chk_run);
      int lat;
      bit done;
      in_valid  = 1'b1;
      a         = av;
      dir       = dv;
      amount    = amt;
      out_ready = (hold == 0);
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 20) begin
         tick();
         lat++;
         in_valid = 1'b0;
         a        = 8'hEE;
         dir      = ~dv;
         amount   = 3'd7;
         if (out_valid) begin
            done = 1'b1;
         end else if (chk_run) begin
            check({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
            check({tag, ".busy_run"}, 32'(busy), 32'd1);
         end
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".result"}, 32'(result), 32'(exp_res));
      check({tag, ".zero"}, 32'(zero), 32'(exp_res == 8'h00));
      check({tag, ".msb"}, 32'(msb), 32'(exp_res[7]));
      check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_result"}, 32'(result), 32'(exp_res));
      end
      out_ready = 1'b1;
      tick();
      check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 8'h00;
      dir       = 1'b0;
      amount    = 3'd0;
      out_ready = 1'b1;
      tick();
      tick();
      check("reset.result", 32'(result), 32'h0);
      check("reset.zero", 32'(zero), 32'd0);
      check("reset.msb", 32'(msb), 32'd0);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();

      run_op("ror1_81", 8'h81, 1'b1, 3'd1, 2, 8'hC0, 0, 1'b1);
      run_op("rol3_96", 8'h96, 1'b0, 3'd3, 4, 8'hB4, 0, 1'b1);
      run_op("ror0_5a", 8'h5A, 1'b1, 3'd0, 1, 8'h5A, 0, 1'b0);
`ifdef ROT_SHORTPATH_EN
      run_op("rol5_00", 8'h00, 1'b0, 3'd5, 4, 8'h00, 0, 1'b1);
`else
      run_op("rol5_00", 8'h00, 1'b0, 3'd5, 6, 8'h00, 0, 1'b1);
`endif
      run_op("bp_rol2_01", 8'h01, 1'b0, 3'd2, 3, 8'h04, 5, 1'b1);

      // Asynchronous reset during the third RUN cycle of a 6-step rotate.
      in_valid = 1'b1;
      a        = 8'h55;
      dir      = 1'b0;
      amount   = 3'd6;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrst.result", 32'(result), 32'h0);
      check("midrst.zero", 32'(zero), 32'd0);
      check("midrst.msb", 32'(msb), 32'd0);
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.busy", 32'(busy), 32'd0);
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();

      run_op("ror4_10", 8'h10, 1'b1, 3'd4, 5, 8'h01, 0, 1'b1);
`ifdef ROT_SHORTPATH_EN
      run_op("rol7_01", 8'h01, 1'b0, 3'd7, 2, 8'h80, 0, 1'b1);
`else
      run_op("rol7_01", 8'h01, 1'b0, 3'd7, 8, 8'h80, 0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rotate_seq_ctrl.md
Name: rotate_seq_ctrl

Overview:
- Multi-cycle rotate sequencer for the 8-bit ALU core.
- Accepts an operand, a direction and a rotate amount over a valid/ready handshake.
- Applies one single-bit rotate per clock until the amount is exhausted, then presents the result and flags downstream.
- Sits between the ALU operand/decode stage and the ALU result register. It extends the single-step rotate datapath to arbitrary amounts.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 3, width of the amount field; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a request.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  operand.
- dir  input  1  1 = rotate right (bit i takes bit i+1, MSB takes bit 0); 0 = rotate left.
- amount  input  CNT_W  number of single-bit rotates, 0..WIDTH-1.
- out_valid  output  1  result, zero and msb are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  rotated operand.
- zero  output  1  result == 0.
- msb  output  1  result[WIDTH-1].
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; result=0; zero=0; msb=0; out_valid=0; busy=0; internal counter=0. An in-flight operation is discarded.
- State IDLE: in_ready=1.
  - On in_valid && in_ready: latch a into the working register, and latch dir and amount.
  - amount==0 -> DONE; otherwise -> RUN.
- State RUN: each edge rotates the working register by one bit in the latched direction and decrements the counter.
  - The edge that performs the last rotate (counter==1) moves to DONE.
  - in_ready=0; inputs are ignored.
- State DONE: out_valid=1.
  - result, zero and msb are registered and stable until the handshake.
  - On out_valid && out_ready -> IDLE. No new request is accepted in the same cycle, because in_ready is 0 in DONE.
- Latency: out_valid rises amount+1 cycles after the accept edge (amount=0 -> 1 cycle).
- Throughput: at most one operation per amount+2 cycles.
- Flags: computed from the final working register value and registered together with result. They are not meaningful while out_valid=0; in that state they hold their previous value, or 0 after reset.
- Backpressure: out_ready low holds DONE indefinitely with all outputs unchanged.
- No arithmetic carry is involved; bits wrap purely modulo WIDTH.
- Amounts of WIDTH or more are unrepresentable because amount is CNT_W bits wide.

Optional Feature:
- Macro: ROT_SHORTPATH_EN.
- Defined: at accept, if amount > WIDTH/2, the block latches the opposite direction and a step count of WIDTH-amount. result is bit-identical to the long path. Latency becomes min(amount, WIDTH-amount)+1.
- Undefined: the block always performs exactly amount steps in the requested direction.

Decomposition:
- Package rot_pkg contains:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE;
  - DIR_LEFT=0 and DIR_RIGHT=1;
  - a function computing one single-bit rotate of a WIDTH vector.
- One sub-module is natural: rot_flag_gen, combinational, producing zero and msb from a WIDTH vector. The flags are registered in the parent.

Test Plan:
- a=0x81, dir=1, amount=1 -> result=0xC0, msb=1, zero=0, out_valid 2 cycles after accept.
- a=0x96, dir=0, amount=3 -> result=0xB4, latency 4 cycles; in_ready=0 and busy=1 throughout RUN.
- a=0x5A, dir=1, amount=0 -> result=0x5A, latency 1. Then a=0x00, amount=5 -> result=0x00, zero=1.
- Backpressure: complete a=0x01, dir=0, amount=2 with out_ready low for 5 cycles -> result=0x04 held stable with out_valid=1. After out_ready rises, IDLE and in_ready=1 on the following cycle.
- Reset mid-RUN: accept amount=6, assert rst during the 3rd RUN cycle -> all outputs 0 and state IDLE immediately (asynchronous). A next request a=0x10, dir=1, amount=4 -> result=0x01.
- a=0x01, dir=0, amount=7 -> result=0x80.
  - With ROT_SHORTPATH_EN: latency 2.
  - Without: latency 8.
